adc_mv_averager: RTL and testbench
==================================

Name: adc_mv_averager

Overview:
- Upstream feeder for the diffraction-order calculator; produces the 12-bit `L_mV` operand that stage consumes.
- Accepts raw 12-bit ADC codes over a valid/ready handshake and averages a power-of-two window of samples.
- Scales the average to millivolts, saturates it and publishes it on a held register with a one-cycle valid pulse.
- The register stays stable between updates, so the free-running downstream stage can sample it at any point in its 21-cycle frame.

Parameters:
- LOG2_AVG, 4, window size 2^LOG2_AVG samples; legal range 1..8.
- FULL_SCALE_MV, 4096, mV value corresponding to code 2^12; legal range 1..8191.
- CLAMP_MIN_MV, 1, lower output bound when the optional clamp is compiled in.

Ports:
- clk_50  in  1  system clock; all logic on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  sample_code is valid this cycle.
- sample_code  in  12  raw unsigned ADC code.
- sample_ready  out  1  block accepts a sample this cycle.
- flush  in  1  synchronous window restart.
- L_mV  out  12  averaged, scaled voltage in mV; held between updates.
- L_mV_valid  out  1  one-cycle pulse when L_mV updates.
- overrange  out  1  sticky until next publish: last published value saturated at 4095.

Behaviour:
- Clocking and reset: one clock, clk_50; reset_n is asynchronous, active-low.
- Reset values:
  - state = ACCUM; accumulator = 0; sample count = 0.
  - L_mV = 0 (CLAMP_MIN_MV if ADC_AVG_CLAMP_EN is defined).
  - L_mV_valid = 0; overrange = 0; sample_ready = 0 while reset_n is low.
- Handshake:
  - sample_ready = (state==ACCUM) && !flush.
  - A sample is accepted on an edge where sample_valid && sample_ready.
  - sample_valid may be held high; the source must not change sample_code until the sample is accepted.
- State ACCUM:
  - On accept: accumulator += sample_code; count += 1.
  - Accumulator width is 12+LOG2_AVG bits, so it never overflows.
  - When the accepted sample is number 2^LOG2_AVG: go to SCALE; count wraps to 0.
- State SCALE (1 cycle):
  - avg = accumulator >> LOG2_AVG (truncating).
  - prod = avg * FULL_SCALE_MV, a 25-bit unsigned value.
  - mv = prod >> 12.
  - If mv > 4095: mv_sat = 4095 and ovr = 1; otherwise mv_sat = mv and ovr = 0.
  - Register mv_sat and ovr; go to PUBLISH.
- State PUBLISH (1 cycle):
  - L_mV <= mv_sat; overrange <= ovr; L_mV_valid pulses high in the following cycle.
  - Clear the accumulator; go to ACCUM.
- Latency: the last sample is accepted at edge E. L_mV and L_mV_valid change at edge E+2. sample_ready is low for the two cycles between E and E+2.
- flush:
  - In ACCUM: clears the accumulator and count at that edge. A simultaneous sample_valid is not accepted, because ready is low.
  - In SCALE or PUBLISH: ignored; the in-flight result still publishes.
- L_mV holds its value indefinitely when no samples arrive; no timeout.
- Reset mid-window or mid-SCALE: partial sum is discarded and outputs return to their reset values immediately.

Optional Feature:
- Macro ADC_AVG_CLAMP_EN.
- Defined: published value = max(mv_sat, CLAMP_MIN_MV), and L_mV resets to CLAMP_MIN_MV. L_mV is therefore never 0, so the downstream log never sees log(0). overrange is unaffected by the lower clamp.
- Undefined: no lower clamp; L_mV may be 0 and resets to 0.

Decomposition:
- Package adc_avg_pkg:
  - ADC_BITS=12 and MV_BITS=12.
  - State encoding ACCUM=2'd0, SCALE=2'd1, PUBLISH=2'd2.
  - Saturation limit MV_MAX=12'd4095.
- Sub-module mv_scaler:
  - Purely combinational: avg, FULL_SCALE_MV -> mv_sat, ovr (plus the clamp under the macro).
  - Registered by the parent in SCALE.
  - Unit-testable in isolation.

Test Plan:
- LOG2_AVG=2, FULL_SCALE_MV=4096; accept 100,200,300,400 back-to-back -> L_mV=250 and L_mV_valid pulse exactly 2 edges after the 4th accept; sample_ready low for those 2 cycles.
- LOG2_AVG=2, FULL_SCALE_MV=2048; samples 4095 x4 -> L_mV=2047; overrange=0.
- LOG2_AVG=2, FULL_SCALE_MV=8191; samples 4095 x4 -> L_mV=4095; overrange=1. A following window of 100 x4 -> L_mV=199; overrange=0.
- Accept 2 samples (1000,1000); assert flush with sample_valid high -> that sample is not accepted. Then 4x 8 -> L_mV=8, not influenced by the 1000s.
- With ADC_AVG_CLAMP_EN: after reset L_mV=1; window of 4x 0 -> L_mV=1. Without the macro: after reset L_mV=0 and the same window -> L_mV=0.
- Assert reset_n low after 3 of 4 samples -> outputs are 0 asynchronously. Then 4x 40 -> L_mV=40 (no residue from the aborted window).

Source files
------------

// File: rtl/adc_avg_pkg.sv
// Shared widths, FSM encoding and the saturation limit for the ADC millivolt averager.
package adc_avg_pkg;

    localparam int ADC_BITS = 12;
    localparam int MV_BITS  = 12;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        SCALE   = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    localparam logic [MV_BITS-1:0] MV_MAX = 12'd4095;

endpackage

// File: rtl/adc_mv_averager_mv_scaler.sv
// Combinational code-to-millivolt scaler with saturation at MV_MAX.
// Optional lower clamp to CLAMP_MIN_MV when ADC_AVG_CLAMP_EN is defined.
module mv_scaler
    import adc_avg_pkg::*;
#(
    parameter int FULL_SCALE_MV = 4096,
    parameter int CLAMP_MIN_MV  = 1
) (
    input  logic [ADC_BITS-1:0] avg_i,
    output logic [MV_BITS-1:0]  mv_sat_o,
    output logic                ovr_o
);

    localparam logic [12:0] FULL_SCALE = 13'(FULL_SCALE_MV);
`ifdef ADC_AVG_CLAMP_EN
    localparam logic [MV_BITS-1:0] MV_FLOOR = MV_BITS'(CLAMP_MIN_MV);
`endif

    logic [24:0] prod;
    logic [12:0] mv;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        prod     = 25'(avg_i) * 25'(FULL_SCALE);
        mv       = prod[24:12];
        mv_sat_o = mv[MV_BITS-1:0];
        ovr_o    = 1'b0;
        if (mv > 13'(MV_MAX)) begin
            mv_sat_o = MV_MAX;
            ovr_o    = 1'b1;
        end
`ifdef ADC_AVG_CLAMP_EN
        // The downstream log stage must never see 0 mV; overrange is independent of this floor.
        if (mv_sat_o < MV_FLOOR) begin
            mv_sat_o = MV_FLOOR;
        end
`endif
    end

endmodule

// File: rtl/adc_mv_averager.sv
// Averages 2^LOG2_AVG ADC codes, scales to mV and publishes on a held register with a valid pulse.
// Build option ADC_AVG_CLAMP_EN: lower-clamps the published value (and reset value) to CLAMP_MIN_MV.
module adc_mv_averager
    import adc_avg_pkg::*;
#(
    parameter int LOG2_AVG      = 4,
    parameter int FULL_SCALE_MV = 4096,
    parameter int CLAMP_MIN_MV  = 1
) (
    input  logic                clk_50,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [ADC_BITS-1:0] sample_code,
    output logic                sample_ready,
    input  logic                flush,
    output logic [MV_BITS-1:0]  L_mV,
    output logic                L_mV_valid,
    output logic                overrange
);

    localparam int ACC_W = ADC_BITS + LOG2_AVG;
`ifdef ADC_AVG_CLAMP_EN
    localparam logic [MV_BITS-1:0] MV_RESET = MV_BITS'(CLAMP_MIN_MV);
`else
    localparam logic [MV_BITS-1:0] MV_RESET = '0;
`endif

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_AVG-1:0] cnt_q, cnt_d;
    logic [MV_BITS-1:0]  mv_q, mv_d;
    logic                ovr_q, ovr_d;
    logic [MV_BITS-1:0]  l_mv_q, l_mv_d;
    logic                l_valid_q, l_valid_d;
    logic                ovr_out_q, ovr_out_d;

    logic [ADC_BITS-1:0] avg;
    logic [MV_BITS-1:0]  scaled_mv;
    logic                scaled_ovr;

    assign avg = acc_q[ACC_W-1:LOG2_AVG];

    mv_scaler #(
        .FULL_SCALE_MV (FULL_SCALE_MV),
        .CLAMP_MIN_MV  (CLAMP_MIN_MV)
    ) u_mv_scaler (
        .avg_i    (avg),
        .mv_sat_o (scaled_mv),
        .ovr_o    (scaled_ovr)
    );

    // Gated by reset_n so the source sees no acceptance while reset is held.
    assign sample_ready = (state_q == ACCUM) && !flush && reset_n;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mv_d      = mv_q;
        ovr_d     = ovr_q;
        l_mv_d    = l_mv_q;
        l_valid_d = 1'b0;
        ovr_out_d = ovr_out_q;
        case (state_q)
            ACCUM: begin
                if (flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (sample_valid) begin
                    acc_d = acc_q + ACC_W'(sample_code);
                    cnt_d = cnt_q + LOG2_AVG'(1);
                    if (cnt_q == '1) begin
                        state_d = SCALE;
                    end
                end
            end
            SCALE: begin
                mv_d    = scaled_mv;
                ovr_d   = scaled_ovr;
                state_d = PUBLISH;
            end
            PUBLISH: begin
                l_mv_d    = mv_q;
                ovr_out_d = ovr_q;
                l_valid_d = 1'b1;
                acc_d     = '0;
                state_d   = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            mv_q      <= MV_RESET;
            ovr_q     <= 1'b0;
            l_mv_q    <= MV_RESET;
            l_valid_q <= 1'b0;
            ovr_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mv_q      <= mv_d;
            ovr_q     <= ovr_d;
            l_mv_q    <= l_mv_d;
            l_valid_q <= l_valid_d;
            ovr_out_q <= ovr_out_d;
        end
    end

    assign L_mV       = l_mv_q;
    assign L_mV_valid = l_valid_q;
    assign overrange  = ovr_out_q;

endmodule

// File: tb/tb_adc_mv_averager.sv
// Directed bench: three averagers (full scale 4096/2048/8191, window of 4) driven in parallel.
module tb_adc_mv_averager;

`ifdef ADC_AVG_CLAMP_EN
    localparam logic [11:0] ZMV = 12'd1;
`else
    localparam logic [11:0] ZMV = 12'd0;
`endif

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [11:0] sample_code;
    logic        flush;

    logic        rdy_a, rdy_b, rdy_c;
    logic [11:0] mv_a, mv_b, mv_c;
    logic        val_a, val_b, val_c;
    logic        ovr_a, ovr_b, ovr_c;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk_50 = ~clk_50;

    adc_mv_averager #(.LOG2_AVG(2), .FULL_SCALE_MV(4096), .CLAMP_MIN_MV(1)) dut_a (
        .clk_50(clk_50), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_code(sample_code), .sample_ready(rdy_a), .flush(flush),
        .L_mV(mv_a), .L_mV_valid(val_a), .overrange(ovr_a));

    adc_mv_averager #(.LOG2_AVG(2), .FULL_SCALE_MV(2048), .CLAMP_MIN_MV(1)) dut_b (
        .clk_50(clk_50), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_code(sample_code), .sample_ready(rdy_b), .flush(flush),
        .L_mV(mv_b), .L_mV_valid(val_b), .overrange(ovr_b));

    adc_mv_averager #(.LOG2_AVG(2), .FULL_SCALE_MV(8191), .CLAMP_MIN_MV(1)) dut_c (
        .clk_50(clk_50), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_code(sample_code), .sample_ready(rdy_c), .flush(flush),
        .L_mV(mv_c), .L_mV_valid(val_c), .overrange(ovr_c));

    typedef struct packed {
        logic [3:0][11:0] s;
        logic [11:0]      exp_a;
        logic [11:0]      exp_b;
        logic [11:0]      exp_c;
        logic             ovr_c;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic [11:0] s0, s1, s2, s3,
                                input logic [11:0] ea, eb, ec, input logic oc);
        vec_t v;
        v.s     = {s3, s2, s1, s0};
        v.exp_a = ea;
        v.exp_b = eb;
        v.exp_c = ec;
        v.ovr_c = oc;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [11:0] code);
        bit done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk_50);
            sample_valid = 1'b1;
            sample_code  = code;
            if (rdy_a) begin
                @(posedge clk_50);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: sample %0d never accepted, expected acceptance", code);
        end
    endtask

    task automatic run_window(input vec_t v, input bit flush_late);
        for (int i = 0; i < 4; i++) push(v.s[i]);
        @(negedge clk_50);
        sample_valid = 1'b0;
        flush        = flush_late;
        check("ready_scale", 16'(rdy_a), 16'd0);
        check("valid_scale", 16'(val_a), 16'd0);
        @(negedge clk_50);
        check("ready_publish", 16'(rdy_a), 16'd0);
        check("valid_publish", 16'(val_a), 16'd0);
        @(negedge clk_50);
        check("valid_a", 16'(val_a), 16'd1);
        check("valid_c", 16'(val_c), 16'd1);
        check("mv_a", 16'(mv_a), 16'(v.exp_a));
        check("mv_b", 16'(mv_b), 16'(v.exp_b));
        check("mv_c", 16'(mv_c), 16'(v.exp_c));
        check("ovr_a", 16'(ovr_a), 16'd0);
        check("ovr_b", 16'(ovr_b), 16'd0);
        check("ovr_c", 16'(ovr_c), 16'(v.ovr_c));
        check("ready_back", 16'(rdy_b), 16'(!flush_late));
        flush = 1'b0;
        @(negedge clk_50);
        check("valid_pulse_end", 16'(val_b), 16'd0);
        check("mv_a_held", 16'(mv_a), 16'(v.exp_a));
    endtask

    initial begin
        vecs[0] = mk(100, 200, 300, 400,     250,  125,  499, 1'b0);
        vecs[1] = mk(4095, 4095, 4095, 4095, 4095, 2047, 4095, 1'b1);
        vecs[2] = mk(100, 100, 100, 100,     100,  50,   199, 1'b0);
        vecs[3] = mk(0, 0, 0, 0,             ZMV,  ZMV,  ZMV, 1'b0);
        vecs[4] = mk(1, 1, 1, 1,             1,    ZMV,  1,   1'b0);
        vecs[5] = mk(1, 2, 3, 5,             2,    1,    3,   1'b0);
        vecs[6] = mk(4095, 4095, 4095, 4092, 4094, 2047, 4095, 1'b1);
        vecs[7] = mk(3, 3, 3, 3,             3,    1,    5,   1'b0);
        vecs[8] = mk(1000, 2000, 3000, 4000, 2500, 1250, 4095, 1'b1);

        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_code  = '0;
        flush        = 1'b0;
        #5;
        check("rst_mv_a", 16'(mv_a), 16'(ZMV));
        check("rst_mv_c", 16'(mv_c), 16'(ZMV));
        check("rst_valid", 16'(val_a), 16'd0);
        check("rst_ovr", 16'(ovr_c), 16'd0);
        check("rst_ready", 16'(rdy_a), 16'd0);
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", 16'(rdy_a), 16'd1);

        for (int i = 0; i < 9; i++) run_window(vecs[i], 1'b0);

        // Flush during SCALE/PUBLISH must not disturb the in-flight result.
        run_window(mk(200, 200, 200, 200, 200, 100, 399, 1'b0), 1'b1);

        // Flush in ACCUM discards the partial sum and blocks the concurrent sample.
        push(1000);
        push(1000);
        @(negedge clk_50);
        sample_valid = 1'b1;
        sample_code  = 12'd1000;
        flush        = 1'b1;
        #1;
        check("ready_flush", 16'(rdy_a), 16'd0);
        @(negedge clk_50);
        flush        = 1'b0;
        sample_valid = 1'b0;
        run_window(mk(8, 8, 8, 8, 8, 4, 15, 1'b0), 1'b0);

        // Re-establish an overrange result, then abort a window with reset.
        run_window(vecs[8], 1'b0);
        push(500);
        push(500);
        push(500);
        @(negedge clk_50);
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("abort_mv_a", 16'(mv_a), 16'(ZMV));
        check("abort_mv_c", 16'(mv_c), 16'(ZMV));
        check("abort_ovr_c", 16'(ovr_c), 16'd0);
        check("abort_valid", 16'(val_a), 16'd0);
        check("abort_ready", 16'(rdy_a), 16'd0);
        @(negedge clk_50);
        reset_n = 1'b1;
        run_window(mk(40, 40, 40, 40, 40, 20, 79, 1'b0), 1'b0);

        repeat (10) @(negedge clk_50);
        check("idle_hold_mv", 16'(mv_a), 16'd40);
        check("idle_hold_valid", 16'(val_a), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
